// File: rtl/product_accumulator_if.sv
// ============================================================================
// product_accumulator_if : product-in / frame-sum-out handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  // master: upstream producer plus downstream consumer side
  modport master (
    output in_valid,
    output in_product,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_overflow
  );

  // slave: the accumulator itself
  modport slave (
    input  in_valid,
    input  in_product,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_overflow
  );
endinterface

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator : sums COUNT unsigned products per frame, holds result
// Revision: 1.0
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int COUNT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  product_accumulator_if.slave bus,
  output logic                 busy,
  output logic [7:0]           count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST = 8'(COUNT);

  generate
    if (ACC_W < PROD_W || COUNT < 1 || COUNT > 255) begin : g_bad_params
      $error("product_accumulator: illegal ACC_W/PROD_W/COUNT combination");
    end
  endgenerate

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic [7:0]       count_q;

  logic             accept;
  logic             handoff;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   acc_sum_d;

  assign bus.in_ready = (state_q != HOLD);
  assign accept       = bus.in_valid & bus.in_ready;
  assign handoff      = out_valid_q & bus.out_ready;
  assign prod_ext     = ACC_W'(bus.in_product);
  // extra top bit captures the carry that leaves the accumulator width
  assign acc_sum_d    = {1'b0, acc_q} + {1'b0, prod_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_sum_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= prod_ext;
            ovf_q   <= 1'b0;
            count_q <= 8'd1;
            if (C_LAST == 8'd1) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= prod_ext;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q   <= acc_sum_d[ACC_W-1:0];
            ovf_q   <= ovf_q | acc_sum_d[ACC_W];
            count_q <= count_q + 8'd1;
            if (count_q + 8'd1 == C_LAST) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_sum_d[ACC_W-1:0];
            end
          end
        end
        HOLD: begin
          if (handoff) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = ovf_q;
  assign busy             = (state_q == ACCUM);
  assign count            = count_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// tb_product_accumulator : directed checks on three accumulator configurations
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic clk;
  logic rst_n;
  logic clear;

  int n_chk;
  int n_err;

  product_accumulator_if #(.PROD_W(16), .ACC_W(24)) bus8  ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(17)) bus17 ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(24)) bus1  ();

  logic       busy8,  busy17,  busy1;
  logic [7:0] count8, count17, count1;

  product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus8),
    .busy  (busy8),
    .count (count8)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(17), .COUNT(3)) u_dut17 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus17),
    .busy  (busy17),
    .count (count17)
  );

  product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus1),
    .busy  (busy1),
    .count (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [15:0] v);
    chk("dut8 in_ready before accept", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid   = 1'b1;
    bus8.in_product = v;
    tick();
    bus8.in_valid   = 1'b0;
  endtask

  task automatic push17(input logic [15:0] v);
    bus17.in_valid   = 1'b1;
    bus17.in_product = v;
    tick();
    bus17.in_valid   = 1'b0;
  endtask

  task automatic push1(input logic [15:0] v);
    bus1.in_valid   = 1'b1;
    bus1.in_product = v;
    tick();
    bus1.in_valid   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    bus8.in_valid  = 1'b0; bus8.in_product  = '0; bus8.out_ready  = 1'b0;
    bus17.in_valid = 1'b0; bus17.in_product = '0; bus17.out_ready = 1'b0;
    bus1.in_valid  = 1'b0; bus1.in_product  = '0; bus1.out_ready  = 1'b0;

    // reset state
    repeat (2) tick();
    chk("reset out_valid", 32'(bus8.out_valid), 32'd0);
    chk("reset out_sum", 32'(bus8.out_sum), 32'd0);
    chk("reset out_overflow", 32'(bus8.out_overflow), 32'd0);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset count", 32'(count8), 32'd0);
    chk("reset in_ready", 32'(bus8.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // back-to-back frame of 8 x FFFF
    for (int i = 0; i < 7; i++) push8(16'hFFFF);
    chk("t1 out_valid before last", 32'(bus8.out_valid), 32'd0);
    chk("t1 busy mid-frame", 32'(busy8), 32'd1);
    chk("t1 count after 7", 32'(count8), 32'd7);
    push8(16'hFFFF);
    chk("t1 out_valid", 32'(bus8.out_valid), 32'd1);
    chk("t1 out_sum", 32'(bus8.out_sum), 32'h07FFF8);
    chk("t1 out_overflow", 32'(bus8.out_overflow), 32'd0);
    chk("t1 count held", 32'(count8), 32'd8);
    chk("t1 busy in hold", 32'(busy8), 32'd0);
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    chk("t1 out_valid after handoff", 32'(bus8.out_valid), 32'd0);
    chk("t1 count after handoff", 32'(count8), 32'd0);

    // gapped input, then back-pressure while held
    bus8.in_product = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      bus8.in_valid = (i % 2 == 0);
      tick();
    end
    chk("t2 out_valid", 32'(bus8.out_valid), 32'd1);
    chk("t2 count", 32'(count8), 32'd8);
    bus8.in_valid   = 1'b1;
    bus8.in_product = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2 in_ready held", 32'(bus8.in_ready), 32'd0);
      chk("t2 out_sum held", 32'(bus8.out_sum), 32'h07FFF8);
      chk("t2 count held", 32'(count8), 32'd8);
      chk("t2 out_valid held", 32'(bus8.out_valid), 32'd1);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    chk("t2 out_valid released", 32'(bus8.out_valid), 32'd0);
    chk("t2 in_ready idle", 32'(bus8.in_ready), 32'd1);
    chk("t2 busy idle", 32'(busy8), 32'd0);
    chk("t2 count idle", 32'(count8), 32'd0);

    // narrow accumulator wrap and overflow flag
    push17(16'hFFFF);
    push17(16'hFFFF);
    push17(16'h0003);
    chk("t3 out_valid", 32'(bus17.out_valid), 32'd1);
    chk("t3 out_sum wrap", 32'(bus17.out_sum), 32'h00001);
    chk("t3 out_overflow", 32'(bus17.out_overflow), 32'd1);
    bus17.out_ready = 1'b1;
    tick();
    bus17.out_ready = 1'b0;
    push17(16'h0001);
    push17(16'h0002);
    push17(16'h0003);
    chk("t3 second out_sum", 32'(bus17.out_sum), 32'd6);
    chk("t3 second out_overflow", 32'(bus17.out_overflow), 32'd0);
    bus17.out_ready = 1'b1;
    tick();
    bus17.out_ready = 1'b0;

    // clear mid-frame with in_valid asserted
    for (int i = 0; i < 4; i++) push8(16'h0001);
    chk("t4 count before clear", 32'(count8), 32'd4);
    chk("t4 busy before clear", 32'(busy8), 32'd1);
    bus8.in_valid   = 1'b1;
    bus8.in_product = 16'h0001;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus8.in_valid = 1'b0;
    chk("t4 count after clear", 32'(count8), 32'd0);
    chk("t4 busy after clear", 32'(busy8), 32'd0);
    chk("t4 out_valid after clear", 32'(bus8.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) push8(16'h0001);
    chk("t4 out_valid", 32'(bus8.out_valid), 32'd1);
    chk("t4 out_sum", 32'(bus8.out_sum), 32'd8);
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;

    // single-product frames
    push1(16'h1234);
    chk("t5 out_valid", 32'(bus1.out_valid), 32'd1);
    chk("t5 out_sum", 32'(bus1.out_sum), 32'h001234);
    chk("t5 count", 32'(count1), 32'd1);
    chk("t5 in_ready held", 32'(bus1.in_ready), 32'd0);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    chk("t5 out_valid after handoff", 32'(bus1.out_valid), 32'd0);

    // asynchronous reset mid-ACCUM
    for (int i = 0; i < 3; i++) push8(16'h0005);
    chk("t6 busy before reset", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 accum busy", 32'(busy8), 32'd0);
    chk("t6 accum count", 32'(count8), 32'd0);
    chk("t6 accum out_sum", 32'(bus8.out_sum), 32'd0);
    chk("t6 accum out_valid", 32'(bus8.out_valid), 32'd0);
    chk("t6 accum in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // asynchronous reset mid-HOLD
    push1(16'h00AB);
    chk("t6 hold out_valid before", 32'(bus1.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 hold out_valid", 32'(bus1.out_valid), 32'd0);
    chk("t6 hold out_sum", 32'(bus1.out_sum), 32'd0);
    chk("t6 hold count", 32'(count1), 32'd0);
    chk("t6 hold in_ready", 32'(bus1.in_ready), 32'd1);
    chk("t6 hold out_overflow", 32'(bus1.out_overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
